// File: rtl/entry_gate_if.sv
// Keypad byte channel: valid/ready handshake carrying one ASCII character.
// master drives key_valid/key_data, slave answers with key_ready.
interface entry_gate_if;
    logic       key_valid;
    logic       key_ready;
    logic [7:0] key_data;

    modport master (
        output key_valid,
        output key_data,
        input  key_ready
    );

    modport slave (
        input  key_valid,
        input  key_data,
        output key_ready
    );
endinterface

// File: rtl/entry_gate_seq.sv
// Entry gate sequencer: debounced IR pulse, then set + confirm password capture.
// Build option KEY_BACKSPACE_EN: key 8'h08 erases the previous character.
module entry_gate_seq #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int STROBE_CYCLES   = 4,
    parameter int PASS_BYTES      = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ir_raw,
    entry_gate_if.slave             kbus,
    output logic                    ir,
    output logic [8*PASS_BYTES-1:0] pass_entry1,
    output logic                    enter1,
    output logic [8*PASS_BYTES-1:0] pass_entry2,
    output logic                    enter2,
    output logic                    busy,
    output logic                    timeout
);

    localparam int PW = 8 * PASS_BYTES;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW = $clog2(STROBE_CYCLES + 1);
    localparam int IW = $clog2(PASS_BYTES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        IR_PULSE,
        COLLECT1,
        STROBE1,
        COLLECT2,
        STROBE2,
        WAIT_CLEAR
    } state_e;

    state_e          state_q, state_d;
    logic            sync1_q, sync2_q;
    logic            lvl_q, lvl_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic [SW-1:0]   scnt_q, scnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [PW-1:0]   pass1_q, pass1_d;
    logic [PW-1:0]   pass2_q, pass2_d;
    logic            gone_q, gone_d;
    logic            timeout_q, timeout_d;

    logic            collecting;
    logic            xfer;
    logic            is_bs;
    logic            strobe_done;
    logic            last_byte;
    logic [PW-1:0]   cur_w;
    logic [PW-1:0]   new_w;

    // Slot 0 sits in the top byte so the first typed character is the MSB.
    function automatic logic [PW-1:0] put_byte(
        input logic [PW-1:0] w,
        input logic [IW-1:0] i,
        input logic [7:0]    b
    );
        logic [PW-1:0] r;
        r = w;
        r[PW-8-8*int'(i) +: 8] = b;
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= ir_raw;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive samples that disagree with the accepted level.
    always_comb begin
        lvl_d  = lvl_q;
        dcnt_d = '0;
        if (sync2_q != lvl_q) begin
            if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                lvl_d = ~lvl_q;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end
    end

    assign collecting  = (state_q == COLLECT1) || (state_q == COLLECT2);
    assign kbus.key_ready = collecting && lvl_q;
    assign xfer        = kbus.key_valid && kbus.key_ready;
    assign strobe_done = (scnt_q == SW'(STROBE_CYCLES - 1));
    assign last_byte   = (idx_q == IW'(PASS_BYTES - 1));

`ifdef KEY_BACKSPACE_EN
    assign is_bs = (kbus.key_data == 8'h08);
`else
    assign is_bs = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        scnt_d    = scnt_q;
        idx_d     = idx_q;
        tcnt_d    = tcnt_q;
        pass1_d   = pass1_q;
        pass2_d   = pass2_q;
        gone_d    = gone_q;
        timeout_d = 1'b0;
        cur_w     = (state_q == COLLECT2) ? pass2_q : pass1_q;
        new_w     = cur_w;

        unique case (state_q)
            IDLE: begin
                gone_d = 1'b0;
                if (lvl_q) begin
                    state_d = IR_PULSE;
                    scnt_d  = '0;
                    idx_d   = '0;
                    pass1_d = '0;
                    pass2_d = '0;
                end
            end
            IR_PULSE: begin
                gone_d = gone_q | ~lvl_q;
                scnt_d = scnt_q + 1'b1;
                if (strobe_done) begin
                    scnt_d  = '0;
                    tcnt_d  = '0;
                    gone_d  = 1'b0;
                    state_d = (gone_q || !lvl_q) ? IDLE : COLLECT1;
                end
            end
            COLLECT1, COLLECT2: begin
                if (!lvl_q) begin
                    state_d = IDLE;
                end else if (xfer) begin
                    tcnt_d = '0;
                    if (is_bs) begin
                        if (idx_q != '0) begin
                            idx_d = idx_q - 1'b1;
                            new_w = put_byte(cur_w, idx_q - 1'b1, 8'h00);
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                        new_w = put_byte(cur_w, idx_q, kbus.key_data);
                        if (last_byte) begin
                            scnt_d  = '0;
                            state_d = (state_q == COLLECT1) ? STROBE1 : STROBE2;
                        end
                    end
                end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = WAIT_CLEAR;
                    timeout_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
                if (state_q == COLLECT1) begin
                    pass1_d = new_w;
                end else begin
                    pass2_d = new_w;
                end
            end
            STROBE1: begin
                gone_d = gone_q | ~lvl_q;
                scnt_d = scnt_q + 1'b1;
                if (strobe_done) begin
                    scnt_d  = '0;
                    idx_d   = '0;
                    tcnt_d  = '0;
                    gone_d  = 1'b0;
                    state_d = (gone_q || !lvl_q) ? IDLE : COLLECT2;
                end
            end
            STROBE2: begin
                gone_d = gone_q | ~lvl_q;
                scnt_d = scnt_q + 1'b1;
                if (strobe_done) begin
                    scnt_d  = '0;
                    gone_d  = 1'b0;
                    state_d = (gone_q || !lvl_q) ? IDLE : WAIT_CLEAR;
                end
            end
            WAIT_CLEAR: begin
                if (!lvl_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lvl_q     <= 1'b0;
            dcnt_q    <= '0;
            scnt_q    <= '0;
            idx_q     <= '0;
            tcnt_q    <= '0;
            pass1_q   <= '0;
            pass2_q   <= '0;
            gone_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lvl_q     <= lvl_d;
            dcnt_q    <= dcnt_d;
            scnt_q    <= scnt_d;
            idx_q     <= idx_d;
            tcnt_q    <= tcnt_d;
            pass1_q   <= pass1_d;
            pass2_q   <= pass2_d;
            gone_q    <= gone_d;
            timeout_q <= timeout_d;
        end
    end

    // Strobes decode straight from state so reset drops them asynchronously.
    assign ir          = (state_q == IR_PULSE);
    assign enter1      = (state_q == STROBE1);
    assign enter2      = (state_q == STROBE2);
    assign busy        = (state_q != IDLE);
    assign timeout     = timeout_q;
    assign pass_entry1 = pass1_q;
    assign pass_entry2 = pass2_q;

endmodule
